// File: rtl/matrix_frame_capture_pkg.sv
// Shared definitions for the 8x8 LED matrix: geometry constants, frame
// types and the pixel index mapping. Also used by the game core and the
// simulation scoreboard, so everything here must stay generic.
package matrix_frame_capture_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int FRAME_BITS  = MATRIX_ROWS * MATRIX_COLS;
  // Enough bits to hold 0..FRAME_BITS inclusive (7 for a 64-pixel frame).
  localparam int COUNT_BITS  = $clog2(FRAME_BITS + 1);

  typedef logic [MATRIX_COLS-1:0] row_bits_t;
  typedef logic [FRAME_BITS-1:0]  frame_t;
  typedef logic [COUNT_BITS-1:0]  count_t;

  // Pixel (row r, column c) lives at frame bit r*8+c.
  function automatic int pixel_index(input int r, input int c);
    return r * MATRIX_COLS + c;
  endfunction

endpackage

// File: rtl/matrix_frame_capture_popcount.sv
// matrix_popcount: purely combinational count of set bits in a full frame.
// Ports:
//   bits  in  FRAME_BITS  frame to count
//   count out COUNT_BITS  number of set bits (0..FRAME_BITS)
module matrix_popcount
  import matrix_frame_capture_pkg::*;
(
  input  logic [FRAME_BITS-1:0] bits,
  output logic [COUNT_BITS-1:0] count
);

  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    count = '0;
    for (int i = 0; i < FRAME_BITS; i++) begin
      count = count + COUNT_BITS'(bits[i]);
    end
  end

endmodule

// File: rtl/matrix_frame_capture.sv
// matrix_frame_capture: receive side of the 8x8 LED matrix scan bus.
// Samples col/row_n on each scan tick, ORs the lit columns into every
// selected row, and after WINDOW ticks publishes the accumulated frame.
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   col           in   8  column bus, bit c=1 lights column c
//   row_n         in   8  row bus, bit r=0 selects row r
//   sample_en     in   1  one-cycle scan tick
//   frame         out  64 published frame, bit r*8+c = pixel (r,c)
//   frame_valid   out  1  one-cycle strobe when the outputs update
//   lit_count     out  7  set bits in frame
//   frame_changed out  1  frame differs from the previous published frame
module matrix_frame_capture
  import matrix_frame_capture_pkg::*;
#(
  parameter int WINDOW      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [MATRIX_COLS-1:0] col,
  input  logic [MATRIX_ROWS-1:0] row_n,
  input  logic                   sample_en,
  output logic [FRAME_BITS-1:0]  frame,
  output logic                   frame_valid,
  output logic [COUNT_BITS-1:0]  lit_count,
  output logic                   frame_changed
);

  localparam int CW = $clog2(WINDOW);

  // Synchroniser chains. The tick travels through the same number of
  // stages as the data so a tick always qualifies the bus value it came with.
  logic [SYNC_STAGES-1:0][MATRIX_COLS-1:0] col_pipe;
  logic [SYNC_STAGES-1:0][MATRIX_ROWS-1:0] row_pipe;
  logic [SYNC_STAGES-1:0]                  tick_pipe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_pipe  <= '0;
      row_pipe  <= '0;
      tick_pipe <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      col_pipe[0]  <= col;
      row_pipe[0]  <= row_n;
      tick_pipe[0] <= sample_en;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        col_pipe[i]  <= col_pipe[i-1];
        row_pipe[i]  <= row_pipe[i-1];
        tick_pipe[i] <= tick_pipe[i-1];
      end
    end
  end

  logic [MATRIX_COLS-1:0] col_s;
  logic [MATRIX_ROWS-1:0] row_s;
  logic                   tick;

  assign col_s = col_pipe[SYNC_STAGES-1];
  assign row_s = row_pipe[SYNC_STAGES-1];
  assign tick  = tick_pipe[SYNC_STAGES-1];

  logic [FRAME_BITS-1:0] acc;
  logic [FRAME_BITS-1:0] acc_next;
  logic [CW-1:0]         win_cnt;
  logic                  last_tick;
  logic [COUNT_BITS-1:0] acc_next_count;

  // Accumulator including the current tick's contribution; a blank row bus
  // (all ones) leaves it unchanged.
  always_comb begin
    acc_next = acc;
    if (tick) begin
      for (int r = 0; r < MATRIX_ROWS; r++) begin
        if (!row_s[r]) begin
          acc_next[pixel_index(r, 0) +: MATRIX_COLS] =
            acc_next[pixel_index(r, 0) +: MATRIX_COLS] | col_s;
        end
      end
    end
  end

  assign last_tick = tick && (win_cnt == CW'(WINDOW - 1));

  matrix_popcount u_popcount (
    .bits  (acc_next),
    .count (acc_next_count)
  );

  // The published frame register doubles as the previous-frame reference
  // for frame_changed, since it always holds the last published value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      win_cnt       <= '0;
      frame         <= '0;
      frame_valid   <= 1'b0;
      lit_count     <= '0;
      frame_changed <= 1'b0;
    end else if (last_tick) begin
      frame         <= acc_next;
      lit_count     <= acc_next_count;
      frame_changed <= (acc_next != frame);
      frame_valid   <= 1'b1;
      // Clear on the publishing edge so the next window starts empty
      // without dropping the following tick.
      acc           <= '0;
      win_cnt       <= '0;
    end else begin
      frame_valid <= 1'b0;
      acc         <= acc_next;
      if (tick) begin
        win_cnt <= win_cnt + CW'(1);
      end
    end
  end

endmodule
